// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand-forwarding selects and load-use / branch hazard
// controls for a 5-stage RV32I core. A shadow pipeline (EX, MEM, WB) mirrors
// the destination/source registers of in-flight instructions.
// Optional: define FWD_HAZARD_STATS_EN to add the saturating stall_count port.
module fwd_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_wr,
  input  logic              id_is_load,
  input  logic              br_taken,
  output logic [1:0]        FselA,
  output logic [1:0]        FselB,
  output logic              stall_if_id,
  output logic              bubble_id_ex,
  output logic              flush_if_id
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_count
`endif
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_wr;
    logic              is_load;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } shd_t;

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] LU_STALL = 1'b1;

  shd_t       ex_q, mem_q, wb_q;
  logic [0:0] state, state_nxt;
  logic       mem_wr, wb_wr, load_use;

  // x0 is never a forwarding source, so "writes" excludes rd==0
  assign mem_wr = mem_q.valid && mem_q.reg_wr && (mem_q.rd != '0);
  assign wb_wr  = wb_q.valid  && wb_q.reg_wr  && (wb_q.rd  != '0);

  // Forward selects from registered state only; MEM (youngest) beats WB
  always_comb begin
    FselA = 2'b00;
    FselB = 2'b00;
    if (ex_q.valid) begin
      if (mem_wr && mem_q.rd == ex_q.rs1)     FselA = 2'b01;
      else if (wb_wr && wb_q.rd == ex_q.rs1)  FselA = 2'b10;
      if (mem_wr && mem_q.rd == ex_q.rs2)     FselB = 2'b01;
      else if (wb_wr && wb_q.rd == ex_q.rs2)  FselB = 2'b10;
    end
  end

  // Load in EX feeding the instruction in ID: one bubble lets it reach MEM
  assign load_use = id_valid && ex_q.valid && ex_q.is_load && ex_q.reg_wr &&
                    (ex_q.rd != '0) && (ex_q.rd == id_rs1 || ex_q.rd == id_rs2);

  // Taken branch wins: the ID instruction is wrong-path, so flush not stall.
  // rst_n gating keeps outputs quiet while reset is held regardless of br_taken.
  assign flush_if_id  = rst_n && br_taken;
  assign stall_if_id  = rst_n && load_use && !br_taken;
  assign bubble_id_ex = rst_n && (load_use || br_taken);

  // Next-state: the stall lasts one cycle, EX then holds a bubble
  always_comb begin
    state_nxt = RUN;
    case (state)
      RUN:      state_nxt = (load_use && !br_taken) ? LU_STALL : RUN;
      LU_STALL: state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Shadow pipeline advance; a bubble enters EX on stall or flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (bubble_id_ex) ex_q <= '0;
      else              ex_q <= '{valid: id_valid, rd: id_rd, reg_wr: id_reg_wr,
                                  is_load: id_is_load, rs1: id_rs1, rs2: id_rs2};
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  // Saturating count of load-use stall cycles, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                stall_count <= '0;
    else if (stall_if_id && !(&stall_count))   stall_count <= stall_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed test-plan sequences followed by random
// traffic, all checked against a history-array model of in-flight instructions.
module tb_fwd_hazard_ctrl;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_reg_wr, id_is_load, br_taken;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic [1:0]    FselA, FselB;
  logic          stall_if_id, bubble_id_ex, flush_if_id;
`ifdef FWD_HAZARD_STATS_EN
  logic [15:0]   stall_count;
`endif

  fwd_hazard_ctrl #(.REG_AW(AW), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
    .id_is_load(id_is_load), .br_taken(br_taken), .FselA(FselA),
    .FselB(FselB), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
    .flush_if_id(flush_if_id)
`ifdef FWD_HAZARD_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Model: hist[0] = instruction now in EX, hist[1] = MEM, hist[2] = WB
  typedef struct { bit v; bit wr; bit ld; int rd; int rs1; int rs2; } ins_t;
  ins_t hist [3];
  int   m_cnt;
  int   nchk = 0, npass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit produces(ins_t i);
    return i.v && i.wr && i.rd != 0;
  endfunction

  // Youngest older instruction that writes rs supplies the operand
  function automatic logic [1:0] m_fsel(int rs);
    if (!hist[0].v) return 2'b00;
    for (int d = 1; d <= 2; d++)
      if (produces(hist[d]) && hist[d].rd == rs) return 2'(d);
    return 2'b00;
  endfunction

  function automatic bit m_lu();
    return id_valid && hist[0].ld && produces(hist[0]) &&
           (hist[0].rd == int'(id_rs1) || hist[0].rd == int'(id_rs2));
  endfunction

  function automatic void m_clear();
    for (int d = 0; d < 3; d++) hist[d] = '{0, 0, 0, 0, 0, 0};
    m_cnt = 0;
  endfunction

  // Compare every output against the model for the current cycle
  task automatic check_all();
    bit lu, br;
    lu = m_lu();
    br = br_taken;
    if (!rst_n) begin lu = 0; br = 0; end
    chk("fselA", 32'(FselA), rst_n ? 32'(m_fsel(hist[0].rs1)) : 0);
    chk("fselB", 32'(FselB), rst_n ? 32'(m_fsel(hist[0].rs2)) : 0);
    chk("stall", 32'(stall_if_id), 32'(lu && !br));
    chk("bubble", 32'(bubble_id_ex), 32'(lu || br));
    chk("flush", 32'(flush_if_id), 32'(br));
`ifdef FWD_HAZARD_STATS_EN
    chk("stall_count", 32'(stall_count), 32'(m_cnt));
`endif
  endtask

  task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                       input bit wr, input bit ld, input bit br);
    id_valid = v; id_rs1 = AW'(rs1); id_rs2 = AW'(rs2); id_rd = AW'(rd);
    id_reg_wr = wr; id_is_load = ld; br_taken = br;
    #1 check_all();
  endtask

  // Clock edge plus model advance
  task automatic tick();
    bit lu, bub;
    lu  = m_lu() && !br_taken;
    bub = m_lu() || br_taken;
    @(posedge clk);
    if (!rst_n) m_clear();
    else begin
      if (lu && m_cnt != 16'hffff) m_cnt++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (bub) hist[0] = '{0, 0, 0, 0, 0, 0};
      else hist[0] = '{id_valid, id_reg_wr, id_is_load, int'(id_rd), int'(id_rs1), int'(id_rs2)};
    end
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
  endtask

  initial begin
    bit held;
    int c0;
    m_clear();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #12 rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // ALU chain: add x5 ; sub uses x5 -> MEM forward
    drive(1, 1, 2, 5, 1, 0, 0); tick();
    drive(1, 5, 6, 8, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("alu_chain_A", 32'(FselA), 32'h1);
    chk("alu_chain_stall", 32'(stall_if_id), 32'h0);
    tick();

    // Distance 2 -> WB forward; then both MEM and WB write x7 -> MEM wins
    drive(1, 1, 1, 7, 1, 0, 0); tick();
    drive(1, 2, 3, 9, 1, 0, 0); tick();
    drive(1, 1, 7, 10, 1, 0, 0); tick();
    chk("dist2_B", 32'(FselB), 32'h2);
    drive(1, 1, 1, 7, 1, 0, 0); tick();
    drive(1, 1, 1, 7, 1, 0, 0); tick();
    drive(1, 1, 7, 10, 1, 0, 0); tick();
    chk("mem_over_wb_B", 32'(FselB), 32'h1);
    nop(); nop();

    // Load-use: lw x3 ; add uses x3 -> one stall, then WB forward
    c0 = m_cnt;
    drive(1, 1, 2, 3, 1, 1, 0); tick();
    drive(1, 3, 4, 11, 1, 0, 0);
    chk("lu_stall", 32'(stall_if_id), 32'h1);
    chk("lu_bubble", 32'(bubble_id_ex), 32'h1);
    tick();
    drive(1, 3, 4, 11, 1, 0, 0);
    chk("lu_no_second_stall", 32'(stall_if_id), 32'h0);
    tick();
    chk("lu_fwd_A", 32'(FselA), 32'h2);
`ifdef FWD_HAZARD_STATS_EN
    chk("lu_count", 32'(stall_count), 32'(c0 + 1));
`endif
    nop(); nop();

    // x0 and non-writers never forward
    drive(1, 1, 2, 0, 1, 0, 0); tick();
    drive(1, 0, 0, 12, 1, 0, 0); tick();
    chk("x0_A", 32'(FselA), 32'h0);
    nop(); nop();
    drive(1, 1, 2, 4, 0, 0, 0); tick();
    drive(1, 4, 4, 12, 1, 0, 0); tick();
    chk("nowr_A", 32'(FselA), 32'h0);
    nop(); nop();

    // Branch overrides load-use
    c0 = m_cnt;
    drive(1, 1, 2, 3, 1, 1, 0); tick();
    drive(1, 3, 4, 11, 1, 0, 1);
    chk("br_flush", 32'(flush_if_id), 32'h1);
    chk("br_bubble", 32'(bubble_id_ex), 32'h1);
    chk("br_nostall", 32'(stall_if_id), 32'h0);
    tick();
`ifdef FWD_HAZARD_STATS_EN
    chk("br_count", 32'(stall_count), 32'(c0));
`endif
    nop(); nop();

    // Reset during a stall cycle: outputs drop without a clock edge
    drive(1, 1, 2, 3, 1, 1, 0); tick();
    drive(1, 3, 3, 11, 1, 0, 0);
    chk("pre_rst_stall", 32'(stall_if_id), 32'h1);
    rst_n = 1'b0;
    br_taken = 1'b1;
    #1 check_all();
    chk("rst_stall", 32'(stall_if_id), 32'h0);
    chk("rst_bubble", 32'(bubble_id_ex), 32'h0);
    chk("rst_flush", 32'(flush_if_id), 32'h0);
    br_taken = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(1, 6, 6, 13, 1, 0, 0); tick();
    drive(1, 13, 13, 14, 1, 0, 0); tick();
    drive(1, 6, 6, 0, 0, 0, 0); tick();
    chk("post_rst_A", 32'(FselA), 32'h0);
    chk("post_rst_B", 32'(FselB), 32'h0);
    nop();

    // Random traffic; ID holds across a stall, and is a NOP after a flush
    held = 0;
    for (int i = 0; i < 400; i++) begin
      bit stall_prev, flush_prev;
      stall_prev = stall_if_id;
      flush_prev = flush_if_id;
      if (stall_prev) drive(id_valid, int'(id_rs1), int'(id_rs2), int'(id_rd),
                            id_reg_wr, id_is_load, ($urandom_range(0, 7) == 0));
      else if (flush_prev) drive(0, 0, 0, 0, 0, 0, 0);
      else drive(($urandom_range(0, 9) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
      tick();
      held = held | stall_prev;
    end
    chk("rand_saw_stall", 32'(held), 32'h1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end
endmodule
